data_mem_arbiter: RTL
=====================

# data_mem_arbiter

Shares the single data memory between the Memory pipeline stage and a debug/loader port. It sits between the MEM-stage pipeline register outputs and the data memory. The pipeline owns the memory by default. A debug request is served in any cycle the pipeline leaves the memory idle; if the pipeline keeps it busy, the arbiter steals one cycle by stalling the pipeline after a bounded wait.

## Interface
Parameters:
- STARVE_LIMIT, 4: number of consecutive blocked cycles before a debug request is forced through; legal range 1..15.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- MemReqM  in  1  pipeline needs memory this cycle (MemWriteM | MemtoRegM).
- MemWriteM  in  1  pipeline store enable.
- ALUOutM  in  32  pipeline address.
- WriteDataM  in  32  pipeline store data.
- RDM  out  32  read data to pipeline; equals MemRD.
- StallM  out  1  freezes the F/D/E/M pipeline registers for this cycle.
- DbgReq  in  1  debug request; held high with fields stable until DbgAck.
- DbgWE  in  1  debug access is a write.
- DbgAddr  in  32  debug address.
- DbgWData  in  32  debug write data.
- DbgAck  out  1  one-cycle completion pulse.
- DbgRData  out  32  registered read data, valid while DbgAck is high.
- MemA  out  32  memory address.
- MemWD  out  32  memory write data.
- MemWE  out  1  memory write enable.
- MemRD  in  32  memory combinational read data.

## Operation
- States: IDLE, WAIT, ACK. A 4-bit starvation counter `cnt` tracks blocked cycles.
- Grant (combinational) = DbgReq & (state != ACK) & (!MemReqM | cnt == STARVE_LIMIT).
- Steal = grant & MemReqM. On a steal cycle StallM = 1 and the pipeline access is suppressed. That access is retried next cycle because the pipeline holds.
- Memory mux:
  - On grant: MemA = DbgAddr, MemWD = DbgWData, MemWE = DbgWE.
  - Otherwise: MemA = ALUOutM, MemWD = WriteDataM, MemWE = MemWriteM & MemReqM.
- Transitions:
  - IDLE or WAIT, grant → ACK. Capture DbgRData ← MemRD (reads and writes alike). Set cnt ← 0.
  - IDLE or WAIT, DbgReq & !grant → WAIT. Set cnt ← cnt + 1, saturating at STARVE_LIMIT.
  - IDLE or WAIT, !DbgReq → IDLE. Set cnt ← 0.
  - ACK → IDLE unconditionally. DbgAck = 1 only in ACK.
- Requester protocol: DbgReq must be low in the cycle after DbgAck. The arbiter ignores DbgReq in ACK, so back-to-back requests are spaced by at least one cycle.
- DbgReq dropped in WAIT (protocol violation): return to IDLE, cnt ← 0, no access performed.
- StallM is never high outside a steal cycle, and never high in two consecutive cycles.

## Timing
- Reset (RST_N low at a rising edge): state ← IDLE, cnt ← 0, DbgAck ← 0, DbgRData ← 0.
- While RST_N is low, grant is forced 0, StallM = 0, and MemWE = 0. Reset mid-WAIT or mid-ACK drops the pending debug request silently; the requester must re-issue it.
- Free-slot latency: DbgReq seen in cycle t with MemReqM = 0 → access in t, DbgAck in t+1.
- Worst-case latency under continuous MemReqM: access in cycle t+STARVE_LIMIT, DbgAck in t+STARVE_LIMIT+1. Pipeline loses exactly one cycle per forced debug access.
- DbgReq and MemReqM rising in the same cycle with cnt = 0 and STARVE_LIMIT ≥ 1: pipeline wins.
- Memory write timing is the memory's own: write commits on the CLK edge ending the granted cycle.
- RDM is combinational from MemRD. During a steal cycle RDM carries debug data, and the pipeline must ignore it because StallM = 1.

## Structure
- Shared header arb_defs.vh, include-guarded: state encodings ARB_IDLE = 2'd0, ARB_WAIT = 2'd1, ARB_ACK = 2'd2; counter width ARB_CNT_W = 4.
- One sub-module, starve_counter: saturating up-counter with synchronous clear, active-low reset, and an at_limit compare output.
- The top module holds the FSM, the grant logic, and the address/data muxes.

## Test plan
- Free slot: MemReqM = 0, DbgReq write 0x0000_0040 ← 0xDEAD_BEEF. Required: MemWE = 1 with the debug fields in the same cycle, DbgAck next cycle, StallM never high. A follow-up debug read of 0x40 returns DbgRData = 0xDEAD_BEEF.
- Starvation: MemReqM held at 1, STARVE_LIMIT = 4, DbgReq read at cycle 0. Required: StallM = 1 only at cycle 4, MemA = DbgAddr at cycle 4, DbgAck at cycle 5, pipeline store of cycle 4 committed at cycle 5.
- Simultaneous arrival: DbgReq and a pipeline store to 0x10 in the same cycle. Required: pipeline store performed that cycle, cnt = 1 next cycle.
- Reset mid-WAIT: RST_N low at cnt = 2. Required: next cycle state IDLE, cnt = 0, DbgAck = 0, DbgRData = 0, StallM = 0, MemWE = 0 throughout reset.
- Protocol edge: DbgReq held high through ACK. Required: no second grant in the ACK cycle, and a new grant no earlier than the cycle after ACK.
- Randomized traffic: MemReqM at 90% duty, STARVE_LIMIT = 1, scoreboarded memory model. Required: no lost or duplicated writes, and StallM never high on two consecutive cycles.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data memory arbiter.
//   arb_state_e : arbiter FSM state encoding
//   ARB_CNT_W   : width of the starvation counter
package data_mem_arbiter_pkg;

  localparam int ARB_CNT_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_ACK  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/data_mem_arbiter_starve_counter.sv
// Saturating up-counter that measures how long a debug request has been
// blocked by pipeline traffic.
//   CLK, RST_N : clock, synchronous active-low reset
//   clr        : synchronous clear (wins over inc)
//   inc        : count one more blocked cycle, saturating at LIMIT
//   at_limit   : count has reached LIMIT
module starve_counter
  import data_mem_arbiter_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam logic [ARB_CNT_W-1:0] LIMIT_C = ARB_CNT_W'(LIMIT);

  logic [ARB_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == LIMIT_C);

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single data memory between the MEM pipeline stage and a
// debug/loader port. The pipeline owns the memory by default; a debug
// access uses any idle cycle, or steals one cycle (stalling the pipeline)
// once it has been blocked STARVE_LIMIT consecutive cycles.
//   CLK, RST_N                          : clock, synchronous active-low reset
//   MemReqM/MemWriteM/ALUOutM/WriteDataM : pipeline access request
//   RDM, StallM                         : read data and stall to the pipeline
//   DbgReq/DbgWE/DbgAddr/DbgWData       : debug request (held until DbgAck)
//   DbgAck, DbgRData                    : completion pulse and captured read data
//   MemA/MemWD/MemWE/MemRD              : data memory port
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ARB_IDLE | no debug request outstanding
// ARB_WAIT | debug request blocked by pipeline traffic, counting
// ARB_ACK  | debug access done last cycle, DbgAck high, DbgReq ignored
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] RDM,
  output logic        StallM,
  input  logic        DbgReq,
  input  logic        DbgWE,
  input  logic [31:0] DbgAddr,
  input  logic [31:0] DbgWData,
  output logic        DbgAck,
  output logic [31:0] DbgRData,
  output logic [31:0] MemA,
  output logic [31:0] MemWD,
  output logic        MemWE,
  input  logic [31:0] MemRD
);

  arb_state_e  state_q, state_d;
  logic [31:0] dbg_rdata_q, dbg_rdata_d;
  logic        in_ack;
  logic        grant;
  logic        blocked;
  logic        at_limit;

  assign in_ack  = (state_q == ARB_ACK);
  // Reset masks the grant so nothing reaches the memory while RST_N is low.
  assign grant   = RST_N & DbgReq & !in_ack & (!MemReqM | at_limit);
  assign blocked = DbgReq & !in_ack & !grant;

  starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .clr      (!blocked),
    .inc      (blocked),
    .at_limit (at_limit)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ARB_IDLE;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      ARB_IDLE, ARB_WAIT: begin
        if (grant) begin
          state_d     = ARB_ACK;
          // Captured on writes too; the requester only looks at it on reads.
          dbg_rdata_d = MemRD;
        end else if (DbgReq) begin
          state_d = ARB_WAIT;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_ACK: state_d = ARB_IDLE;
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    // A grant while the pipeline wants memory is a steal: the pipeline holds
    // its registers and repeats the suppressed access next cycle.
    StallM = grant & MemReqM;
    DbgAck = in_ack;
    if (grant) begin
      MemA  = DbgAddr;
      MemWD = DbgWData;
      MemWE = DbgWE;
    end else begin
      MemA  = ALUOutM;
      MemWD = WriteDataM;
      MemWE = RST_N & MemWriteM & MemReqM;
    end
  end

  assign RDM      = MemRD;
  assign DbgRData = dbg_rdata_q;

endmodule
